memory_responder: RTL and testbench
===================================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the number of extra busy cycles inserted before completion.
REQ-002 The block SHALL have parameter ADDR_W, default 9, meaning the byte-address width (512-byte memory).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port Clk, input, 1 bit: clock, rising-edge active.
REQ-005 The block SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port RAM_enable, input, 1 bit: request strobe, held high by the initiator until MFC is seen.
REQ-007 The block SHALL have port RAM_OpCode, input, 6 bits: SPARC op3 access type.
REQ-008 The block SHALL have port Address, input, ADDR_W bits: byte address.
REQ-009 The block SHALL have port DataIn, input, 32 bits: store data, right-justified.
REQ-010 The block SHALL have port DataOut, output, 32 bits: load result, extended to 32 bits.
REQ-011 The block SHALL have port MFC, output, 1 bit: memory function complete.
REQ-012 The block SHALL have port MERR, output, 1 bit: error flag, valid only while MFC=1.

Function
REQ-013 Supported opcodes SHALL be: LD 000000, LDUB 000001, LDUH 000010, LDSB 001001, LDSH 001010, ST 000100, STB 000101, STH 000110.
REQ-014 The memory SHALL be a byte array of 2^ADDR_W entries, big-endian: byte at Address is bits 31:24 of a word.
REQ-015 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-016 In IDLE, a rising edge with RAM_enable=1 SHALL latch opcode, address and data, load the counter with WAIT_CYCLES, and enter BUSY.
REQ-017 In BUSY, each edge SHALL decrement the counter; at an edge with counter=0 the access SHALL execute and the FSM SHALL enter DONE.
REQ-018 MFC SHALL be registered and rise exactly WAIT_CYCLES+1 edges after the acceptance edge (1 edge when WAIT_CYCLES=0).
REQ-019 Input changes during BUSY SHALL be ignored; only the latched values SHALL be used.
REQ-020 In DONE, MFC SHALL stay 1 while RAM_enable=1; the first edge with RAM_enable=0 SHALL clear MFC and MERR and return to IDLE.
REQ-021 A new request SHALL NOT be accepted in the same edge as the DONE-to-IDLE transition; the minimum gap is one IDLE cycle.
REQ-022 Loads SHALL drive DataOut on entry to DONE: LDUB/LDUH zero-extend, LDSB/LDSH sign-extend, LD returns the full word.
REQ-023 DataOut SHALL hold its value until the next successful load; stores and errors SHALL NOT alter it.
REQ-024 Stores SHALL write DataIn[7:0], DataIn[15:0] or DataIn[31:0] on the edge entering DONE, and never earlier.
REQ-025 A halfword access with Address[0]=1, a word access with Address[1:0]≠00, or an unsupported opcode SHALL set MERR=1 with MFC, perform no memory write and leave DataOut unchanged.
REQ-026 The memory image SHALL NOT be affected by reset.
REQ-027 Address arithmetic SHALL NOT wrap: an aligned access at the top word (0x1FC) SHALL use bytes 0x1FC–0x1FF.

Reset
REQ-028 RESET=0 SHALL immediately force the FSM to IDLE, MFC=0, MERR=0, DataOut=0, counter=0, regardless of Clk.
REQ-029 Reset during BUSY SHALL abort the access; a pending store SHALL NOT be written.
REQ-030 After RESET returns high, the first acceptance SHALL occur no earlier than the first rising edge that samples RAM_enable=1.

Verification
REQ-031 ST 0xDEADBEEF to 0x010, then LD 0x010 -> DataOut=0xDEADBEEF, MERR=0, MFC rising 3 edges after acceptance (WAIT_CYCLES=2).
REQ-032 With 0x010 holding 0xDEADBEEF: LDSB 0x011 -> 0xFFFFFFAD; LDUB 0x011 -> 0x000000AD; LDSH 0x012 -> 0xFFFFBEEF; LDUH 0x010 -> 0x0000DEAD.
REQ-033 STB 0x12345677 to 0x013, then LD 0x010 -> 0xDEADBE77; STH 0x0000ABCD to 0x010, then LD -> 0xABCDBE77.
REQ-034 LD from 0x012 or STH to 0x011 -> MFC=1 with MERR=1, memory unchanged, DataOut holds the previous load value; opcode 111111 -> MERR=1.
REQ-035 Hold RAM_enable=1 for 5 cycles after MFC -> MFC stays 1 and there is no second access; drop RAM_enable -> MFC=0 on the next edge.
REQ-036 ST 0x11111111 to 0x020, assert RESET low during BUSY, then LD 0x020 -> the prior contents are returned, and MFC/MERR/DataOut=0 during reset.

Source files
------------

// File: rtl/memory_responder.sv
// Byte-addressed, big-endian SPARC-style memory responder.
// Accepts one request, waits WAIT_CYCLES, then completes with MFC/MERR held until the strobe drops.
module memory_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 9
) (
    input  logic              Clk,
    input  logic              RESET,
    input  logic              RAM_enable,
    input  logic [5:0]        RAM_OpCode,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MFC,
    output logic              MERR
);

    localparam int unsigned CNT_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned MEM_DEPTH = 1 << ADDR_W;

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [5:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic [7:0]        r_mem [MEM_DEPTH];

    logic              w_valid_op;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_sz_half;
    logic              w_sz_word;
    logic              w_err;
    logic              w_exec;
    logic              w_we;
    logic [31:0]       w_word_rd;
    logic [7:0]        w_byte_rd;
    logic [15:0]       w_half_rd;
    logic [31:0]       w_load_data;

    // Opcode decode of the latched request
    always_comb begin
        w_valid_op = 1'b1;
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_sz_half  = 1'b0;
        w_sz_word  = 1'b0;
        case (r_op)
            OP_LD:   begin w_is_load  = 1'b1; w_sz_word = 1'b1; end
            OP_LDUB: begin w_is_load  = 1'b1; end
            OP_LDUH: begin w_is_load  = 1'b1; w_sz_half = 1'b1; end
            OP_LDSB: begin w_is_load  = 1'b1; end
            OP_LDSH: begin w_is_load  = 1'b1; w_sz_half = 1'b1; end
            OP_ST:   begin w_is_store = 1'b1; w_sz_word = 1'b1; end
            OP_STB:  begin w_is_store = 1'b1; end
            OP_STH:  begin w_is_store = 1'b1; w_sz_half = 1'b1; end
            default: w_valid_op = 1'b0;
        endcase
    end

    assign w_err  = !w_valid_op
                  || (w_sz_half && r_addr[0])
                  || (w_sz_word && (r_addr[1:0] != 2'b00));
    assign w_exec = (r_state == S_BUSY) && (r_cnt == '0);
    assign w_we   = w_exec && w_is_store && !w_err && RESET;

    // Read the containing aligned word, then pick the byte/halfword lane
    assign w_word_rd = {r_mem[{r_addr[ADDR_W-1:2], 2'b00}],
                        r_mem[{r_addr[ADDR_W-1:2], 2'b01}],
                        r_mem[{r_addr[ADDR_W-1:2], 2'b10}],
                        r_mem[{r_addr[ADDR_W-1:2], 2'b11}]};

    always_comb begin
        w_byte_rd = w_word_rd[31:24];
        case (r_addr[1:0])
            2'b00:   w_byte_rd = w_word_rd[31:24];
            2'b01:   w_byte_rd = w_word_rd[23:16];
            2'b10:   w_byte_rd = w_word_rd[15:8];
            default: w_byte_rd = w_word_rd[7:0];
        endcase
    end

    assign w_half_rd = r_addr[1] ? w_word_rd[15:0] : w_word_rd[31:16];

    always_comb begin
        w_load_data = w_word_rd;
        case (r_op)
            OP_LDUB: w_load_data = {24'd0, w_byte_rd};
            OP_LDSB: w_load_data = {{24{w_byte_rd[7]}}, w_byte_rd};
            OP_LDUH: w_load_data = {16'd0, w_half_rd};
            OP_LDSH: w_load_data = {{16{w_half_rd[15]}}, w_half_rd};
            default: w_load_data = w_word_rd;
        endcase
    end

    // Memory array has no reset so its image survives RESET
    always_ff @(posedge Clk) begin
        if (w_we) begin
            if (w_sz_word) begin
                r_mem[{r_addr[ADDR_W-1:2], 2'b00}] <= r_data[31:24];
                r_mem[{r_addr[ADDR_W-1:2], 2'b01}] <= r_data[23:16];
                r_mem[{r_addr[ADDR_W-1:2], 2'b10}] <= r_data[15:8];
                r_mem[{r_addr[ADDR_W-1:2], 2'b11}] <= r_data[7:0];
            end else if (w_sz_half) begin
                r_mem[{r_addr[ADDR_W-1:1], 1'b0}] <= r_data[15:8];
                r_mem[{r_addr[ADDR_W-1:1], 1'b1}] <= r_data[7:0];
            end else begin
                r_mem[r_addr] <= r_data[7:0];
            end
        end
    end

    // Request FSM with registered completion outputs
    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            DataOut <= '0;
            MFC     <= 1'b0;
            MERR    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (RAM_enable) begin
                        r_op    <= RAM_OpCode;
                        r_addr  <= Address;
                        r_data  <= DataIn;
                        r_cnt   <= CNT_W'(WAIT_CYCLES);
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                        MFC     <= 1'b1;
                        MERR    <= w_err;
                        if (w_is_load && !w_err) begin
                            DataOut <= w_load_data;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (!RAM_enable) begin
                        r_state <= S_IDLE;
                        MFC     <= 1'b0;
                        MERR    <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: a byte-array reference model predicts
// each access; results are queued at drive time and compared when MFC rises.
module tb_memory_responder;

    localparam int unsigned WAIT_CYCLES = 2;
    localparam int unsigned ADDR_W      = 9;

    logic        Clk;
    logic        RESET;
    logic        RAM_enable;
    logic [5:0]  RAM_OpCode;
    logic [8:0]  Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MFC;
    logic        MERR;

    typedef struct {
        logic [31:0] dout;
        logic        merr;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  m_mem [512];
    logic [31:0] m_dout;
    int          checks;
    int          errors;

    memory_responder #(.WAIT_CYCLES(WAIT_CYCLES), .ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .RESET(RESET), .RAM_enable(RAM_enable), .RAM_OpCode(RAM_OpCode),
        .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .MFC(MFC), .MERR(MERR)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: apply one access to the byte array, return expected outputs
    task automatic predict(input logic [5:0] op, input logic [8:0] addr, input logic [31:0] data,
                           output exp_t e);
        int          size;
        bit          ld;
        bit          sgn;
        bit          ok;
        logic [31:0] v;
        size = 1; ld = 0; sgn = 0; ok = 1;
        case (op)
            6'b000000: begin ld = 1; size = 4; end
            6'b000001: begin ld = 1; size = 1; end
            6'b000010: begin ld = 1; size = 2; end
            6'b001001: begin ld = 1; size = 1; sgn = 1; end
            6'b001010: begin ld = 1; size = 2; sgn = 1; end
            6'b000100: size = 4;
            6'b000101: size = 1;
            6'b000110: size = 2;
            default:   ok = 0;
        endcase
        if (ok && ((int'(addr) % size) != 0)) ok = 0;
        if (!ok) begin
            e.merr = 1'b1;
        end else begin
            e.merr = 1'b0;
            if (ld) begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v = (v << 8) | {24'd0, m_mem[int'(addr) + i]};
                if (sgn && size == 1) v = {{24{v[7]}}, v[7:0]};
                if (sgn && size == 2) v = {{16{v[15]}}, v[15:0]};
                m_dout = v;
            end else begin
                for (int i = 0; i < size; i++) m_mem[int'(addr) + i] = data[(size - 1 - i) * 8 +: 8];
            end
        end
        e.dout = m_dout;
    endtask

    task automatic run_op(input logic [5:0] op, input logic [8:0] addr, input logic [31:0] data,
                          input int hold);
        exp_t e;
        int   n;
        bit   got;
        predict(op, addr, data, e);
        sb_q.push_back(e);
        @(negedge Clk);
        RAM_enable = 1'b1;
        RAM_OpCode = op;
        Address    = addr;
        DataIn     = data;
        @(posedge Clk);
        #1;
        RAM_OpCode = 6'($urandom);
        Address    = 9'($urandom);
        DataIn     = $urandom;
        n = 0;
        got = 0;
        while (!got && n < 20) begin
            @(posedge Clk);
            #1;
            n++;
            if (MFC) got = 1;
        end
        check("mfc_seen", 32'(got), 32'd1);
        if (got && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("mfc_latency", 32'(n), 32'(WAIT_CYCLES + 1));
            check("merr", 32'(MERR), 32'(e.merr));
            check("dataout", DataOut, e.dout);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge Clk);
            #1;
            check("mfc_hold", 32'(MFC), 32'd1);
            check("dout_hold", DataOut, m_dout);
        end
        @(negedge Clk);
        RAM_enable = 1'b0;
        @(posedge Clk);
        #1;
        check("mfc_clear", 32'(MFC), 32'd0);
        check("merr_clear", 32'(MERR), 32'd0);
    endtask

    initial begin
        logic [5:0] ops [10];
        checks = 0;
        errors = 0;
        m_dout = 32'd0;
        for (int i = 0; i < 512; i++) m_mem[i] = 8'h00;
        ops = '{6'b000000, 6'b000001, 6'b000010, 6'b001001, 6'b001010,
                6'b000100, 6'b000101, 6'b000110, 6'b111111, 6'b000011};
        RESET      = 1'b0;
        RAM_enable = 1'b0;
        RAM_OpCode = 6'd0;
        Address    = 9'd0;
        DataIn     = 32'd0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_mfc", 32'(MFC), 32'd0);
        check("rst_merr", 32'(MERR), 32'd0);
        check("rst_dout", DataOut, 32'd0);
        @(negedge Clk);
        RESET = 1'b1;

        // Basic word/sub-word behaviour around 0x010
        run_op(6'b000100, 9'h010, 32'hDEADBEEF, 0);
        run_op(6'b000000, 9'h010, 32'h0, 0);
        run_op(6'b001001, 9'h011, 32'h0, 0);
        run_op(6'b000001, 9'h011, 32'h0, 0);
        run_op(6'b001010, 9'h012, 32'h0, 0);
        run_op(6'b000010, 9'h010, 32'h0, 0);
        run_op(6'b000101, 9'h013, 32'h12345677, 0);
        run_op(6'b000000, 9'h010, 32'h0, 0);
        run_op(6'b000110, 9'h010, 32'h0000ABCD, 0);
        run_op(6'b000000, 9'h010, 32'h0, 0);

        // Error cases, then proof memory and DataOut were untouched
        run_op(6'b000000, 9'h012, 32'h0, 0);
        run_op(6'b000110, 9'h011, 32'h00005555, 0);
        run_op(6'b111111, 9'h010, 32'h0, 0);
        run_op(6'b000000, 9'h010, 32'h0, 5);

        // Top-of-memory word and no wrap into address 0
        run_op(6'b000100, 9'h000, 32'h01020304, 0);
        run_op(6'b000100, 9'h1FC, 32'hA5B6C7D8, 0);
        run_op(6'b000000, 9'h1FC, 32'h0, 0);
        run_op(6'b000001, 9'h1FF, 32'h0, 0);
        run_op(6'b000000, 9'h000, 32'h0, 0);

        // Randomised mix over a preloaded region
        for (int a = 0; a < 64; a += 4) run_op(6'b000100, 9'(a), $urandom, 0);
        for (int i = 0; i < 40; i++)
            run_op(ops[$urandom_range(0, 9)], 9'($urandom_range(0, 63)), $urandom,
                   int'($urandom_range(0, 2)));

        // Reset during BUSY aborts a pending store
        run_op(6'b000100, 9'h020, 32'hCAFEF00D, 0);
        @(negedge Clk);
        RAM_enable = 1'b1;
        RAM_OpCode = 6'b000100;
        Address    = 9'h020;
        DataIn     = 32'h11111111;
        @(posedge Clk);
        @(negedge Clk);
        RESET = 1'b0;
        #1;
        m_dout = 32'd0;
        check("abort_mfc", 32'(MFC), 32'd0);
        check("abort_merr", 32'(MERR), 32'd0);
        check("abort_dout", DataOut, 32'd0);
        repeat (3) @(posedge Clk);
        #1;
        check("abort_mfc_held", 32'(MFC), 32'd0);
        @(negedge Clk);
        RAM_enable = 1'b0;
        RESET      = 1'b1;
        repeat (2) @(posedge Clk);
        run_op(6'b000000, 9'h020, 32'h0, 0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
